sub_2_block_param: RTL and testbench

Parametrised successor of the 16-bit log-domain subtractor in the softmax COMPUTE stage. It buffers a vector of downscaled values (x_i - max) and waits for the ln(sum) result. It then streams out x_i - max - (ln >> LN_SHIFT) with signed saturation, under ready/valid backpressure. Depth, width and ln alignment are parameters; a done pulse and sticky error/saturation flags are added.

---
 rtl/sub_2_block_param.sv | 191 +++++++++++++++++++
 tb/tb_sub_2_block_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_2_block_param.sv
// Softmax log-domain subtractor: buffers a (x_i - max) vector, waits for ln(sum),
// then streams sat(x_i - max - (ln >> LN_SHIFT)) under ready/valid backpressure.
module sub_2_block_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned LN_SHIFT = 6,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [DATA_W-1:0] sub_2_downscale_data_i,
  input  logic              sub_2_downscale_data_valid_i,
  input  logic [CNT_W-1:0]  sub_2_downscale_number_of_data_i,
  input  logic [DATA_W-1:0] sub_2_ln_data_i,
  input  logic              sub_2_ln_data_valid_i,
  output logic [DATA_W-1:0] sub_2_data_o,
  output logic              sub_2_data_valid_o,
  input  logic              sub_2_data_ready_i,
  output logic              sub_2_done_o,
  output logic              sub_2_sat_o,
  output logic              sub_2_error_o
);

  localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, STREAM, DONE} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q, n_reg_q;
  logic [DATA_W-1:0] ln_reg_q;
  logic              ln_ok_q;

  logic              accept;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              n_load;
  logic              ln_cap;
  logic              load_out;
  logic              err_set;
  logic [CNT_W-1:0]  n_in_clamped;

  logic signed [DATA_W+1:0] op_a, op_b, diff;
  logic [DATA_W-1:0]        sat_val;
  logic                     sat_hit;

  // Two guard bits keep the difference exact for any LN_SHIFT, including 0.
  always_comb begin
    rd_idx  = rd_cnt_q[IDX_W-1:0];
    op_a    = {{2{mem_q[rd_idx][DATA_W-1]}}, mem_q[rd_idx]};
    op_b    = {2'b00, ln_reg_q >> LN_SHIFT};
    diff    = op_a - op_b;
    sat_hit = !((diff[DATA_W+1] == diff[DATA_W]) && (diff[DATA_W] == diff[DATA_W-1]));
    if (!sat_hit) begin
      sat_val = diff[DATA_W-1:0];
    end else if (diff[DATA_W+1]) begin
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_en        = 1'b0;
    wr_idx       = wr_cnt_q[IDX_W-1:0];
    n_load       = 1'b0;
    load_out     = 1'b0;
    err_set      = 1'b0;
    accept       = sub_2_data_valid_o & sub_2_data_ready_i;
    n_in_clamped = (sub_2_downscale_number_of_data_i > DEPTH_C) ?
                   DEPTH_C : sub_2_downscale_number_of_data_i;
    ln_cap       = sub_2_ln_data_valid_i && !ln_ok_q && (state_q != DONE);

    if ((state_q == COLLECT) || (state_q == STREAM)) begin
      if (sub_2_downscale_data_valid_i) begin
        if (wr_cnt_q < n_reg_q) begin
          wr_en = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (sub_2_downscale_data_valid_i) begin
          n_load  = 1'b1;
          err_set = (sub_2_downscale_number_of_data_i > DEPTH_C) ||
                    (sub_2_downscale_number_of_data_i == '0);
          if (sub_2_downscale_number_of_data_i != '0) begin
            wr_en  = 1'b1;
            wr_idx = '0;
          end
          // Ln already held: skip COLLECT so the first beat follows the first write directly.
          state_d = (ln_ok_q && (sub_2_downscale_number_of_data_i != '0)) ? STREAM : COLLECT;
        end
      end
      COLLECT: begin
        if (ln_ok_q) begin
          state_d = (n_reg_q == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if ((!sub_2_data_valid_o || sub_2_data_ready_i) &&
            (rd_cnt_q < wr_cnt_q) && (rd_cnt_q < n_reg_q)) begin
          load_out = 1'b1;
        end
        if (accept && (rd_cnt_q == n_reg_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        err_set = sub_2_downscale_data_valid_i | sub_2_ln_data_valid_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sub_2_done_o = (state_q == DONE);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= sub_2_downscale_data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_cnt_q           <= '0;
      rd_cnt_q           <= '0;
      n_reg_q            <= '0;
      ln_reg_q           <= '0;
      ln_ok_q            <= 1'b0;
      sub_2_data_o       <= '0;
      sub_2_data_valid_o <= 1'b0;
      sub_2_sat_o        <= 1'b0;
      sub_2_error_o      <= 1'b0;
    end else begin
      if (n_load) begin
        n_reg_q <= n_in_clamped;
      end

      if (state_q == DONE) begin
        wr_cnt_q <= '0;
      end else if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end

      if (state_q == DONE) begin
        rd_cnt_q <= '0;
      end else if (load_out) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end

      if (ln_cap) begin
        ln_reg_q <= sub_2_ln_data_i;
        ln_ok_q  <= 1'b1;
      end else if (state_q == DONE) begin
        ln_ok_q <= 1'b0;
      end

      if (load_out) begin
        sub_2_data_o       <= sat_val;
        sub_2_data_valid_o <= 1'b1;
        if (sat_hit) begin
          sub_2_sat_o <= 1'b1;
        end
      end else if (accept || (state_q == DONE)) begin
        sub_2_data_valid_o <= 1'b0;
      end

      if (err_set) begin
        sub_2_error_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sub_2_block_param.sv
// Bench for sub_2_block_param: directed and randomized vectors against a
// queue-based arithmetic reference model.
module tb_sub_2_block_param;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LNS   = 6;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] ds_data;
  logic          ds_valid;
  logic [CW-1:0] ds_n;
  logic [DW-1:0] ln_data;
  logic          ln_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          ready;
  logic          done;
  logic          sat;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_sat  = 1'b0;
  bit exp_err  = 1'b0;
  logic [DW-1:0] elem [64];

  always #5 clk = ~clk;

  sub_2_block_param #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .LN_SHIFT(LNS),
    .CNT_W   (CW)
  ) dut (
    .clock_i                         (clk),
    .reset_n_i                       (rst_n),
    .sub_2_downscale_data_i          (ds_data),
    .sub_2_downscale_data_valid_i    (ds_valid),
    .sub_2_downscale_number_of_data_i(ds_n),
    .sub_2_ln_data_i                 (ln_data),
    .sub_2_ln_data_valid_i           (ln_valid),
    .sub_2_data_o                    (out_data),
    .sub_2_data_valid_o              (out_valid),
    .sub_2_data_ready_i              (ready),
    .sub_2_done_o                    (done),
    .sub_2_sat_o                     (sat),
    .sub_2_error_o                   (err)
  );

  // Plain integer arithmetic: signed element minus shifted unsigned ln, clamped.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] x, input logic [DW-1:0] ln,
                                          output bit s);
    int xs, l, d;
    xs = int'($signed(x));
    l  = int'(ln) >> LNS;
    d  = xs - l;
    s  = 1'b0;
    if (d > (2 ** (DW - 1)) - 1) begin
      d = (2 ** (DW - 1)) - 1;
      s = 1'b1;
    end else if (d < -(2 ** (DW - 1))) begin
      d = -(2 ** (DW - 1));
      s = 1'b1;
    end
    return d[DW-1:0];
  endfunction

  task automatic set_idle();
    ds_valid = 1'b0;
    ds_data  = '0;
    ds_n     = '0;
    ln_valid = 1'b0;
    ln_data  = '0;
    ready    = 1'b1;
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_sat = 1'b0;
    exp_err = 1'b0;
  endtask

  // rmode: 0 random ready, 1 ready high, 2 ready pattern 1,0,0 repeating.
  task automatic run_vec(input int n_in, input int n_send, input bit ln_first,
                         input logic [DW-1:0] ln_val, input int rmode, input int abort_after);
    logic [DW-1:0] q[$];
    logic [DW-1:0] prev_d, e;
    int n_eff, exp_total, beats, last_acc, first_v, prev_beat, off, ln_c, idx;
    bit prev_v, prev_r, done_seen, s, exp_done, rdy;
    n_eff = (n_in > DEPTH) ? DEPTH : n_in;
    for (int i = 0; i < n_send; i++) begin
      if (i < n_eff) begin
        e = model(elem[i], ln_val, s);
        q.push_back(e);
        if (s) exp_sat = 1'b1;
      end
    end
    if (n_in > DEPTH || n_in == 0 || n_send > n_eff) exp_err = 1'b1;
    exp_total = q.size();
    beats = 0; last_acc = -10; first_v = -1; prev_beat = -1;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; done_seen = 1'b0;
    off  = ln_first ? 1 : 0;
    ln_c = ln_first ? 0 : n_send;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      if (out_valid === 1'b1 && first_v < 0) first_v = c;
      if (prev_v && !prev_r) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d)
          $display("FAIL stall_hold: got valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, prev_d);
        else n_pass++;
      end
      if (exp_total > 0) begin
        exp_done = (q.size() == 0) && (last_acc == c - 1);
        n_checks++;
        if (done !== exp_done)
          $display("FAIL done_timing: cycle %0d got done=%b, required %b", c, done, exp_done);
        else n_pass++;
      end
      if (done === 1'b1) done_seen = 1'b1;
      idx      = c - off;
      ds_valid = (idx >= 0 && idx < n_send);
      ds_data  = ds_valid ? elem[idx] : '0;
      ds_n     = CW'(n_in);
      ln_valid = (c == ln_c);
      ln_data  = ln_val;
      case (rmode)
        0:       rdy = 1'($urandom_range(0, 1));
        1:       rdy = 1'b1;
        default: rdy = (c % 3 == 0);
      endcase
      ready = rdy;
      if (out_valid === 1'b1 && rdy) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL extra_beat: got data=%h, required no beat", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e)
            $display("FAIL beat_%0d: got %h, required %h", beats, out_data, e);
          else n_pass++;
        end
        if (rmode == 1 && prev_beat >= 0) begin
          n_checks++;
          if (c != prev_beat + 1)
            $display("FAIL throughput: beat at cycle %0d, required %0d", c, prev_beat + 1);
          else n_pass++;
        end
        prev_beat = c;
        last_acc  = c;
        beats++;
      end
      prev_v = (out_valid === 1'b1);
      prev_r = rdy;
      prev_d = out_data;
      @(posedge clk);
      #1;
      if (abort_after > 0 && beats >= abort_after) begin
        set_idle();
        return;
      end
    end
    set_idle();
    n_checks++;
    if (!done_seen) $display("FAIL done_timeout: got no done pulse, required one");
    else n_pass++;
    n_checks++;
    if (beats != exp_total) $display("FAIL beat_count: got %0d, required %0d", beats, exp_total);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL after_done: got done=%b valid=%b, required 0 0", done, out_valid);
    else n_pass++;
    if (ln_first && exp_total > 0) begin
      n_checks++;
      if (first_v != 3) $display("FAIL first_latency: got cycle %0d, required 3", first_v);
      else n_pass++;
    end
    n_checks++;
    if (sat !== exp_sat) $display("FAIL sat_flag: got %b, required %b", sat, exp_sat);
    else n_pass++;
    n_checks++;
    if (err !== exp_err) $display("FAIL error_flag: got %b, required %b", err, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_data, out_valid, done, sat, err} !== '0)
      $display("FAIL reset_outputs: got data=%h valid=%b done=%b sat=%b err=%b, required all 0",
               out_data, out_valid, done, sat, err);
    else n_pass++;
    apply_reset();
    n_checks++;
    if ({out_valid, done, sat, err} !== '0)
      $display("FAIL post_reset: got valid=%b done=%b sat=%b err=%b, required all 0",
               out_valid, done, sat, err);
    else n_pass++;
  endtask

  task automatic test_basic();
    elem[0] = 16'h0000; elem[1] = 16'hFFF0; elem[2] = 16'h0010;
    run_vec(3, 3, 1'b0, 16'h0400, 1, 0);
  endtask

  task automatic test_ln_first();
    elem[0] = 16'h0000; elem[1] = 16'h0004;
    run_vec(2, 2, 1'b1, 16'h0100, 1, 0);
  endtask

  task automatic test_saturation();
    elem[0] = 16'h8000;
    run_vec(1, 1, 1'b0, 16'hFFFF, 1, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) elem[i] = DW'($urandom);
    run_vec(4, 4, 1'b0, DW'($urandom), 2, 0);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH + 2; i++) elem[i] = DW'($urandom);
    run_vec(DEPTH + 2, DEPTH + 2, 1'b0, DW'($urandom), 1, 0);
  endtask

  task automatic test_zero_len();
    apply_reset();
    elem[0] = DW'($urandom);
    run_vec(0, 1, 1'b0, DW'($urandom), 1, 0);
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) elem[i] = DW'($urandom);
      run_vec(n, n, 1'($urandom_range(0, 1)), DW'($urandom), $urandom_range(0, 1), 0);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) elem[i] = DW'($urandom);
    run_vec(5, 5, 1'b1, DW'($urandom), 1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_data, out_valid, done, sat, err} !== '0)
      $display("FAIL mid_reset_outputs: got data=%h valid=%b done=%b sat=%b err=%b, required all 0",
               out_data, out_valid, done, sat, err);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL mid_reset_hold: got done=%b valid=%b, required 0 0", done, out_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL mid_reset_release: got done=%b valid=%b, required 0 0", done, out_valid);
    else n_pass++;
    exp_sat = 1'b0;
    exp_err = 1'b0;
    elem[0] = DW'($urandom);
    run_vec(1, 1, 1'b0, DW'($urandom), 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ln_first();
    test_saturation();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
